// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_kbd_rx : filtered PS/2 keyboard receiver, E0/F0 decode, FWFT event FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
module ps2_kbd_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000,
  parameter int CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_code,
  output logic                          out_brk,
  output logic                          out_ext,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic [CNT_W-1:0]              release_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, data_sync;
  logic          filt, filt_d;
  logic [FW-1:0] filt_cnt;
  logic          sample, data_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt      <= 1'b1;
      filt_d    <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      filt_d    <= filt;
      if (clk_sync[1] == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt     <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign sample   = filt_d & ~filt;
  assign data_bit = data_sync[1];

  state_t        state, state_nx;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          timeout, stop_ok, good_stop, bad_stop;

  assign timeout   = (state != IDLE) && !sample && (tcnt == TW'(TIMEOUT_CYC - 1));
  assign stop_ok   = (^{shreg, par_bit}) && data_bit;
  assign good_stop = (state == STOP) && sample && stop_ok;
  assign bad_stop  = (state == STOP) && sample && !stop_ok;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample && !data_bit)          state_nx = DATA;
      DATA:    if (sample && bitcnt == 3'd7)     state_nx = PARITY;
      PARITY:  if (sample)                       state_nx = STOP;
      STOP:    if (sample)                       state_nx = IDLE;
      default:                                   state_nx = IDLE;
    endcase
    if (timeout) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      parity_err <= bad_stop;
      frame_err  <= timeout;
      tcnt       <= (state == IDLE || sample) ? '0 : tcnt + 1'b1;
      if (sample) begin
        case (state)
          IDLE:    bitcnt <= '0;
          DATA: begin
            shreg  <= {data_bit, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
          end
          PARITY:  par_bit <= data_bit;
          default: ;
        endcase
      end
    end
  end

  // Prefix flags qualify the next non-prefix byte; any rejected frame drops them.
  logic ext_f, brk_f, push_req;
  assign push_req = good_stop && (shreg != 8'hE0) && (shreg != 8'hF0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_f <= 1'b0;
      brk_f <= 1'b0;
    end else if (bad_stop || timeout) begin
      ext_f <= 1'b0;
      brk_f <= 1'b0;
    end else if (good_stop) begin
      if (shreg == 8'hE0) begin
        ext_f <= 1'b1;
      end else if (shreg == 8'hF0) begin
        brk_f <= 1'b1;
      end else begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nx;
  logic [AW:0]   fill_after_pop;
  logic [9:0]    entry, head_nx;
  logic          full, pop, push;

  assign out_valid      = (fill != '0);
  assign full           = (fill == (AW+1)'(FIFO_DEPTH));
  assign pop            = out_valid & out_ready;
  assign push           = push_req && (!full || pop);
  assign entry          = {ext_f, brk_f, shreg};
  assign rd_nx          = rd_ptr + AW'(pop);
  assign fill_after_pop = fill - (AW+1)'(pop);
  // The head register is fed straight from the push when the FIFO would otherwise go empty.
  assign head_nx        = (fill_after_pop == '0) ? entry : mem[rd_nx];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      overflow    <= 1'b0;
      release_cnt <= '0;
      out_code    <= '0;
      out_brk     <= 1'b0;
      out_ext     <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + AW'(push);
      rd_ptr      <= rd_nx;
      fill        <= fill + (AW+1)'(push) - (AW+1)'(pop);
      overflow    <= overflow | (push_req && full && !pop);
      release_cnt <= release_cnt + CNT_W'(push && brk_f);
      if (fill_after_pop != '0 || push) begin
        {out_ext, out_brk, out_code} <= head_nx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// Scoreboard bench for ps2_kbd_rx: directed PS/2 frames, expected events queued,
// monitor pops and compares on every handshake.
module tb_ps2_kbd_rx;

  localparam int DEPTH = 8;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       rst, ps2_clk, ps2_data, out_ready;
  logic       out_valid, out_brk, out_ext, overflow, parity_err, frame_err;
  logic [7:0] out_code, release_cnt;
  logic [3:0] fill;

  always #5 clk = ~clk;

  ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT_CYC(5000), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_brk(out_brk), .out_ext(out_ext), .fill(fill), .overflow(overflow),
    .parity_err(parity_err), .frame_err(frame_err), .release_cnt(release_cnt)
  );

  int checks = 0, errors = 0;
  int pe_cnt = 0, fe_cnt = 0, v_cnt = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void expect_ev(input bit ext, input bit brk, input logic [7:0] code);
    exp_q.push_back({ext, brk, code});
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (parity_err) pe_cnt++;
      if (frame_err)  fe_cnt++;
      if (out_valid)  v_cnt++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL event: got ext=%0b brk=%0b code=%0h, none expected", out_ext, out_brk, out_code);
        end else begin
          automatic logic [9:0] e = exp_q.pop_front();
          if ({out_ext, out_brk, out_code} !== e) begin
            errors++;
            $display("FAIL event: got ext=%0b brk=%0b code=%0h expected ext=%0b brk=%0b code=%0h",
                     out_ext, out_brk, out_code, e[9], e[8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    cyc(HALF / 2);
    if (glitch) begin
      ps2_clk = 1'b0;
      cyc(2);
      ps2_clk = 1'b1;
    end
    cyc(HALF / 2);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch && (i == 3));
    send_bit((~^b) ^ bad_par, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    cyc(HALF);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((fill != 0 || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, (fill == 0 && exp_q.size() == 0), 1);
  endtask

  initial begin
    int pe0, fe0, v0;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; out_ready = 1'b1;
    cyc(5);
    @(negedge clk);
    chk("rst_flags", {out_valid, out_brk, out_ext, overflow, parity_err, frame_err}, 0);
    chk("rst_code", out_code, 0);
    chk("rst_fill", fill, 0);
    chk("rst_relcnt", release_cnt, 0);
    rst = 1'b0;
    cyc(5);

    v0 = v_cnt;
    expect_ev(0, 0, 8'h1C);
    send_frame(8'h1C, 0, 0);
    wait_drain("single_1C");
    chk("single_valid_cycles", v_cnt - v0, 1);
    chk("single_relcnt", release_cnt, 0);

    expect_ev(0, 1, 8'h1C);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    wait_drain("release_1C");
    chk("release_relcnt", release_cnt, 1);

    expect_ev(1, 1, 8'h75);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    expect_ev(0, 0, 8'h75);
    send_frame(8'h75, 0, 0);
    wait_drain("ext_release_75");
    chk("ext_relcnt", release_cnt, 2);

    pe0 = pe_cnt;
    send_frame(8'h1C, 1, 0);
    cyc(5);
    chk("parity_pulse", pe_cnt - pe0, 1);
    chk("parity_no_push", fill, 0);
    expect_ev(0, 0, 8'h1C);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h1C, 1, 0);
    send_frame(8'h1C, 0, 0);
    wait_drain("prefix_lost");
    chk("parity_pulse2", pe_cnt - pe0, 2);

    fe0 = fe_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
    ps2_data = 1'b1;
    cyc(5200);
    chk("timeout_pulse", fe_cnt - fe0, 1);
    expect_ev(0, 0, 8'h1C);
    send_frame(8'h1C, 0, 0);
    wait_drain("after_timeout");

    expect_ev(0, 0, 8'h5A);
    send_frame(8'h5A, 0, 1);
    wait_drain("glitch");

    out_ready = 1'b0;
    for (int k = 0; k <= DEPTH; k++) begin
      if (k < DEPTH) expect_ev(0, 0, 8'h10 + 8'(k));
      send_frame(8'h10 + 8'(k), 0, 0);
    end
    @(negedge clk);
    chk("full_fill", fill, DEPTH);
    chk("full_overflow", overflow, 1);
    chk("full_head", out_code, 8'h10);
    chk("full_relcnt", release_cnt, 2);
    out_ready = 1'b1;
    wait_drain("overflow_drain");
    chk("overflow_sticky", overflow, 1);

    out_ready = 1'b0;
    send_frame(8'h22, 0, 0);
    @(negedge clk);
    chk("pre_rst_fill", fill, 1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_flags", {out_valid, out_brk, out_ext, overflow}, 0);
    chk("midrst_code_fill", {out_code, fill}, 0);
    chk("midrst_relcnt", release_cnt, 0);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    cyc(5);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    cyc(5);
    expect_ev(0, 0, 8'h1C);
    send_frame(8'h1C, 0, 0);
    wait_drain("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
